// File: rtl/gate_tp_pkg.sv
// Shared defaults for the gate test-pattern lab blocks: widths, synchronizer
// and filter depths, and all-ones constants for the default widths.
package gate_tp_pkg;

  localparam int CNT_W_DEF       = 8;
  localparam int MEAS_W_DEF      = 8;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int FILT_CYCLES_DEF = 4;

  localparam logic [CNT_W_DEF-1:0]  CNT_ONES_DEF  = '1;
  localparam logic [MEAS_W_DEF-1:0] MEAS_ONES_DEF = '1;

  typedef enum logic [1:0] {
    HS_IDLE = 2'b00,
    HS_LOAD = 2'b01,
    HS_DROP = 2'b10
  } hs_act_e;

endpackage

// File: rtl/gate_event_counter_sync_filter.sv
// Synchronizer plus glitch filter for an asynchronous level; reusable for any
// lab input. Exposes next-edge toggle strobes and a registered rise strobe.
module sync_filter
  import gate_tp_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILT_CYCLES = FILT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level_out,
  output logic rise_pulse,
  output logic rise_evt,
  output logic fall_evt
);

  localparam int FC_W = (FILT_CYCLES < 2) ? 1 : $clog2(FILT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [FC_W-1:0]        filt_cnt;
  logic                   sync_lvl;
  logic                   differ;
  logic                   accept;

  assign sync_lvl = sync_q[SYNC_STAGES-1];
  assign differ   = sync_lvl ^ level_out;
  // A change is accepted on the FILT_CYCLES-th consecutive differing sample.
  assign accept   = differ && (filt_cnt == FC_W'(FILT_CYCLES - 1));
  assign rise_evt = accept & ~level_out;
  assign fall_evt = accept & level_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      filt_cnt   <= '0;
      level_out  <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], din};
      rise_pulse <= rise_evt;
      if (accept) begin
        level_out <= ~level_out;
        filt_cnt  <= '0;
      end else if (differ) begin
        filt_cnt  <= filt_cnt + 1'b1;
      end else begin
        filt_cnt  <= '0;
      end
    end
  end

endmodule

// File: rtl/gate_event_counter.sv
// Counts filtered rising edges of the AND-gate output and hands the high-time
// of each accepted pulse to a readout stage over valid/ready.
module gate_event_counter
  import gate_tp_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int MEAS_W      = MEAS_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILT_CYCLES = FILT_CYCLES_DEF,
  parameter int SATURATE    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              z_in,
  input  logic              clear,
  output logic              rise_pulse,
  output logic              level_out,
  output logic [CNT_W-1:0]  event_count,
  output logic [MEAS_W-1:0] meas_len,
  output logic              meas_valid,
  input  logic              meas_ready,
  output logic              meas_ovf
);

  localparam logic [CNT_W-1:0]  CNT_ONES  = '1;
  localparam logic [MEAS_W-1:0] MEAS_ONES = '1;

  logic              rise_evt;
  logic              fall_evt;
  logic [MEAS_W-1:0] high_cnt;
  logic [MEAS_W-1:0] new_meas;
  logic [CNT_W-1:0]  cnt_inc;
  hs_act_e           hs_act;

  sync_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_CYCLES (FILT_CYCLES)
  ) u_sync_filter (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (z_in),
    .level_out  (level_out),
    .rise_pulse (rise_pulse),
    .rise_evt   (rise_evt),
    .fall_evt   (fall_evt)
  );

  assign cnt_inc = (SATURATE != 0 && event_count == CNT_ONES) ? event_count
                                                               : event_count + 1'b1;

  // high_cnt lags the true high-time by one at the falling edge.
  assign new_meas = (high_cnt == MEAS_ONES) ? MEAS_ONES : high_cnt + 1'b1;

  always_comb begin
    hs_act = HS_IDLE;
    if (fall_evt) begin
      if (!meas_valid || meas_ready || clear) hs_act = HS_LOAD;
      else                                     hs_act = HS_DROP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_cnt <= '0;
    end else if (rise_evt) begin
      high_cnt <= '0;
    end else if (level_out && high_cnt != MEAS_ONES) begin
      high_cnt <= high_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      event_count <= '0;
    end else if (clear) begin
      event_count <= rise_evt ? CNT_W'(1) : '0;
    end else if (rise_evt) begin
      event_count <= cnt_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meas_len   <= '0;
      meas_valid <= 1'b0;
      meas_ovf   <= 1'b0;
    end else begin
      case (hs_act)
        HS_LOAD: begin
          meas_len   <= new_meas;
          meas_valid <= 1'b1;
        end
        HS_DROP: meas_ovf <= 1'b1;
        default: if (meas_valid && (meas_ready || clear)) meas_valid <= 1'b0;
      endcase
      if (clear) begin
        meas_ovf <= 1'b0;
        if (hs_act != HS_LOAD) meas_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gate_event_counter.sv
// Directed bench for gate_event_counter: latency, filtering, handshake,
// overflow, clear, wrap/saturate and reset-abort with hand-computed values.
module tb_gate_event_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       z_in;
  logic       clear;
  logic       meas_ready;

  logic       rise_pulse, level_out, meas_valid, meas_ovf;
  logic [7:0] event_count, meas_len;
  logic       s_rise_pulse, s_level_out, s_meas_valid, s_meas_ovf;
  logic [7:0] s_event_count, s_meas_len;

  int n_chk = 0;
  int n_err = 0;
  int rise_seen = 0;

  always #5 clk = ~clk;

  gate_event_counter #(.SATURATE(0)) dut (
    .clk(clk), .rst_n(rst_n), .z_in(z_in), .clear(clear),
    .rise_pulse(rise_pulse), .level_out(level_out), .event_count(event_count),
    .meas_len(meas_len), .meas_valid(meas_valid), .meas_ready(meas_ready),
    .meas_ovf(meas_ovf)
  );

  gate_event_counter #(.SATURATE(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .z_in(z_in), .clear(clear),
    .rise_pulse(s_rise_pulse), .level_out(s_level_out), .event_count(s_event_count),
    .meas_len(s_meas_len), .meas_valid(s_meas_valid), .meas_ready(meas_ready),
    .meas_ovf(s_meas_ovf)
  );

  always @(posedge clk) if (rise_pulse) rise_seen <= rise_seen + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_z(input int hi, input int lo);
    z_in = 1'b1;
    tick(hi);
    z_in = 1'b0;
    tick(lo);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  task automatic pulse_ready();
    meas_ready = 1'b1;
    tick(1);
    meas_ready = 1'b0;
  endtask

  initial begin
    int rise_pos;
    int rise_cnt;
    int r0;

    rst_n = 1'b0; z_in = 1'b1; clear = 1'b0; meas_ready = 1'b0;
    tick(4);
    // 1a: reset holds everything low even with z_in high
    chk("rst_rise",  rise_pulse,  0);
    chk("rst_level", level_out,   0);
    chk("rst_count", event_count, 0);
    chk("rst_len",   meas_len,    0);
    chk("rst_valid", meas_valid,  0);
    chk("rst_ovf",   meas_ovf,    0);
    z_in = 1'b0; rst_n = 1'b1;
    tick(5);

    // 2: 3-cycle glitch is filtered out
    r0 = rise_seen;
    pulse_z(3, 12);
    chk("glitch_rise",  rise_seen - r0, 0);
    chk("glitch_count", event_count,    0);
    chk("glitch_valid", meas_valid,     0);

    // 1b: 10-cycle pulse, rise_pulse on 6th edge, exactly one cycle
    r0 = rise_seen;
    rise_pos = 0; rise_cnt = 0;
    z_in = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      if (rise_pulse) begin rise_cnt++; rise_pos = i; end
    end
    z_in = 1'b0;
    tick(12);
    chk("lat_pos",     rise_pos,       6);
    chk("lat_width",   rise_cnt,       1);
    chk("lat_monitor", rise_seen - r0, 1);
    chk("t1_count",    event_count,    1);
    chk("t1_valid",    meas_valid,     1);
    chk("t1_len",      meas_len,       10);
    pulse_ready();
    chk("t1_consumed", meas_valid,     0);

    // 3: 20-cycle pulse held while not ready, then consumed
    pulse_z(20, 12);
    chk("t3_valid", meas_valid,  1);
    chk("t3_len",   meas_len,    20);
    chk("t3_count", event_count, 2);
    tick(3);
    chk("t3_hold",  meas_len,    20);
    pulse_ready();
    chk("t3_consumed", meas_valid, 0);
    chk("t3_noovf",    meas_ovf,   0);

    // 4: second measurement while unconsumed is dropped
    pulse_z(20, 12);
    pulse_z(12, 12);
    chk("t4_len",   meas_len,    20);
    chk("t4_ovf",   meas_ovf,    1);
    chk("t4_valid", meas_valid,  1);
    chk("t4_count", event_count, 4);
    pulse_clear();
    chk("t4_clr_count", event_count, 0);
    chk("t4_clr_valid", meas_valid,  0);
    chk("t4_clr_ovf",   meas_ovf,    0);

    // minimum accepted pulse: exactly FILT_CYCLES samples high
    pulse_z(4, 12);
    chk("min_count", event_count, 1);
    chk("min_len",   meas_len,    4);
    pulse_clear();

    // 5: 256 accepted pulses wrap / saturate
    for (int i = 0; i < 256; i++) pulse_z(5, 6);
    tick(6);
    chk("wrap_count", event_count,   0);
    chk("sat_count",  s_event_count, 255);
    chk("t5_ovf",     meas_ovf,      1);
    pulse_clear();
    pulse_z(300, 12);
    chk("long_len",   meas_len,   255);
    chk("long_valid", meas_valid, 1);
    chk("long_count", event_count, 1);
    pulse_clear();

    // 6: reset mid-pulse aborts it
    z_in = 1'b1;
    tick(9);
    chk("t6_level", level_out, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_level", level_out,   0);
    chk("t6_rst_rise",  rise_pulse,  0);
    chk("t6_rst_count", event_count, 0);
    chk("t6_rst_len",   meas_len,    0);
    chk("t6_rst_valid", meas_valid,  0);
    chk("t6_rst_ovf",   meas_ovf,    0);
    z_in = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(15);
    chk("t6_post_valid", meas_valid,  0);
    chk("t6_post_count", event_count, 0);
    chk("t6_post_level", level_out,   0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/gate_event_counter.md
Name: gate_event_counter

Overview:
- Downstream stage for the two-input AND gate. Consumes the gate output `z` as an asynchronous level.
- Synchronizes and glitch-filters that level, then emits a one-cycle pulse on each accepted rising edge.
- Counts accepted events and measures the high-time of each accepted pulse.
- Delivers each measurement over a valid/ready handshake to a logging/readout stage.

Parameters:
- CNT_W, 8, event counter width.
- MEAS_W, 8, high-time measurement width.
- SYNC_STAGES, 2, synchronizer flops (≥2).
- FILT_CYCLES, 4, consecutive differing samples needed to accept a level change (≥1; 1 = no filtering).
- SATURATE, 0, 1 = event counter sticks at all-ones, 0 = wraps.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- z_in  in  1  AND gate output, asynchronous to clk.
- clear  in  1  synchronous clear of count, measurement and overflow state.
- rise_pulse  out  1  one-cycle strobe per accepted rising edge.
- level_out  out  1  filtered level.
- event_count  out  CNT_W  accepted rising edges since reset/clear.
- meas_len  out  MEAS_W  high-time of last accepted pulse, in clk cycles.
- meas_valid  out  1  meas_len holds an unconsumed measurement.
- meas_ready  in  1  consumer accepts the measurement.
- meas_ovf  out  1  sticky; a measurement was dropped.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all synchronizer flops, filter state, level_out, rise_pulse, event_count, high-time counter, meas_len, meas_valid and meas_ovf go to 0 immediately.
  - Deassertion is used as-is; the integrating system synchronizes it.
- Synchronizer: z_in passes through SYNC_STAGES flops. The last stage is sync_lvl.
- Filter:
  - The counter increments on each edge where sync_lvl ≠ level_out.
  - It resets to 0 on any edge where they are equal.
  - On the edge where the counter = FILT_CYCLES-1 and the levels still differ, level_out toggles and the counter returns to 0.
- Latency: rise_pulse is high during the cycle after edge number SYNC_STAGES+FILT_CYCLES, where edge 1 is the first edge sampling z_in=1. Defaults give 6.
- rise_pulse:
  - registered; asserted at the same edge level_out goes 0→1.
  - exactly one cycle wide; never asserted on 1→0.
- event_count:
  - increments at the edge rise_pulse is set.
  - SATURATE=0: wraps all-ones→0. SATURATE=1: holds at all-ones.
- High-time counter:
  - clears at the edge level_out goes 0→1, then increments each cycle level_out=1.
  - saturates at all-ones of MEAS_W.
  - On the 1→0 edge it yields N, where N = the number of cycles level_out was 1. This value is the new measurement.
- Handshake (evaluated at each edge):
  - meas_valid & meas_ready: consumed, meas_valid→0, unless a new measurement completes at the same edge; then meas_len←new, meas_valid stays 1, no overflow.
  - !meas_valid and new measurement: meas_len←new, meas_valid→1.
  - meas_valid & !meas_ready and new measurement: meas_len unchanged, new one dropped, meas_ovf→1.
  - meas_len is stable while meas_valid=1 and not consumed.
- clear:
  - zeroes event_count, meas_valid and meas_ovf. Does not touch the synchronizer, filter or high-time counter.
  - Simultaneous with an accepted rise: event_count→1.
  - Simultaneous with a completed measurement: that measurement is loaded, meas_valid→1, meas_ovf→0.
- z_in high at reset release is treated as a normal rising edge after the standard latency and is counted.
- Reset mid-pulse aborts the pulse; no measurement is produced for it.

Decomposition:
- Shared package `gate_tp_pkg` holds:
  - default widths (CNT_W_DEF=8, MEAS_W_DEF=8);
  - default SYNC_STAGES/FILT_CYCLES;
  - a localparam-style all-ones helper per width.
- One sub-module `sync_filter`: the synchronizer plus glitch filter. Outputs level_out and a registered rise strobe. Reusable for the other lab inputs.
- Counting and handshake stay in the top.

Test Plan (defaults; clk period 10 ns):
1. Hold rst_n=0 with z_in=1 → all outputs 0. Release with z_in=0, then raise z_in for 10 cycles → rise_pulse high exactly 1 cycle, at the 6th edge after the rise; event_count=1.
2. z_in high for 3 cycles, then low → no rise_pulse, event_count=0, meas_valid=0.
3. z_in high 20 cycles with meas_ready=0 → after the fall is accepted, meas_valid=1, meas_len=20. Pulse meas_ready one cycle → meas_valid=0.
4. Two accepted pulses (20 then 12 cycles) with meas_ready=0 → meas_len=20, meas_ovf=1. Pulse clear → event_count=0, meas_valid=0, meas_ovf=0.
5. 256 accepted pulses → SATURATE=0: event_count=0. SATURATE=1: event_count=255. A pulse longer than 255 cycles gives meas_len=255.
6. Drop rst_n mid-pulse (level_out=1) → all outputs 0 within the same cycle. After release with z_in low, no measurement appears and event_count=0.
